life_array_grid: RTL and testbench
==================================

# life_array_grid

Parametrised Game-of-Life cell array, ROWS x COLS, with per-cell random-access write, a full-grid serial scan chain and a single-step control. An optional toroidal edge mode, a generation counter and optional stability detection are included. It is the next-generation replacement for the fixed 4x4 tile and sits between the display/readout logic (`alive` bus) and the pattern loader (write port or scan chain).

## Interface
- `ROWS`, 8, grid rows (>=3).
- `COLS`, 8, grid columns (>=3).
- `WRAP`, 0: edges read as dead; 1: toroidal, so row 0 neighbours row ROWS-1 and col 0 neighbours col COLS-1.
- `GEN_W`, 16, generation counter width.
- `RW`/`CW` (localparam), max(1, $clog2(ROWS)) / max(1, $clog2(COLS)).

Ports:
- `clk`  in  1  single clock, all state rising-edge.
- `reset`  in  1  asynchronous, active-low; clears all state while low.
- `alive`  out  ROWS*COLS  cell states; bit index = col*ROWS + row.
- `row`  in  RW  write row address.
- `col`  in  CW  write column address.
- `val`  in  1  write data.
- `write_enb`  in  1  write `val` to cell (`row`,`col`).
- `scan`  in  1  shift whole grid one position.
- `scan_write_val`  in  1  serial data in.
- `scan_write_enb`  in  1  1: inject `scan_write_val`; 0: recirculate.
- `scan_read_val`  out  1  serial out = `alive[ROWS*COLS-1]`.
- `run`  in  1  evolve one generation every cycle.
- `step`  in  1  single-cycle pulse evolves exactly one generation.
- `generation`  out  GEN_W  generations evolved since last load.
- `extinct`  out  1  `alive` == 0 (combinational).
- `stable`  out  1  last evolve produced no change (feature-gated).

## Operation
- Per-cycle action priority: `write_enb` > `scan` > evolve (`run` | `step`) > hold.
- Write: cell (`row`,`col`) <= `val`. An out-of-range address (row>=ROWS or col>=COLS) is ignored entirely, including the counter clear.
- Scan with N = ROWS*COLS: new[0] = `scan_write_enb` ? `scan_write_val` : alive[N-1]; new[i] = alive[i-1]. N scan cycles with `scan_write_enb`=0 restore the grid.
- Evolve uses B3/S23 on all cells simultaneously, from the current registered state only.
  - Neighbour count is 0..8, 4-bit.
  - Next = (cnt==3) | (alive & cnt==2).
  - Off-grid neighbours are 0 unless WRAP=1.
- `step` while `run`=1 is absorbed; it adds no extra generation.
- `generation`:
  - Increments by 1 on each evolve cycle and wraps modulo 2^GEN_W.
  - Clears to 0 on any accepted write or scan cycle.
- `stable` (when compiled in):
  - Registered.
  - Set on an evolve cycle whose next state equals the current state.
  - Cleared on an evolve cycle with change, and on any write or scan.

## Timing
- Reset values: `alive`=0, `generation`=0, `stable`=0, `extinct`=1, `scan_read_val`=0.
- Write, scan and evolve results are visible on `alive` the cycle after the edge; latency is 1.
- `scan_read_val` and `extinct` are combinational from registered state.
- Reset asserted mid-run or mid-scan clears the state immediately. Evolution resumes only on the first edge after release at which `run`/`step` is high.
- `step` is level-sampled, so a pulse held for k cycles gives k generations. The loader guarantees single-cycle pulses.
- Simultaneous `write_enb` and `scan`: only the write occurs, and the scan position does not advance.

## Configuration
- `LIFE_STABLE_DETECT_EN`:
  - Defined: `stable` is implemented as above.
  - Undefined: `stable` is tied to 0 and the comparison logic is removed. All other behaviour is identical.

## Test plan
- ROWS=COLS=5, WRAP=0:
  - Blinker test: write bits 7, 12, 17, then pulse `step` once, giving `alive` bits {11, 12, 13}, `generation`=1. Step again to get back {7, 12, 17}, `generation`=2.
  - Extinction test: load bits {0, 5, 20}, then step, giving `alive`=0, `extinct`=1.
- ROWS=COLS=5, WRAP=1: load bits {0, 5, 20}, then step, giving bits {0, 1, 4}.
- Block test with `LIFE_STABLE_DETECT_EN` defined: load bits 6, 7, 11, 12, then hold `run` for 3 cycles, giving unchanged `alive`, `stable`=1, `generation`=3. A subsequent write sets `stable`=0, `generation`=0.
- ROWS=COLS=4 scan test:
  - Shift in 16 bits of 0xA5C3 (LSB first), with `scan`=1 and `scan_write_enb`=1, giving `alive`=0xC3A5 in bit-reversed order as specified.
  - Then 16 recirculating cycles (`scan_write_enb`=0): `scan_read_val` sequence reproduces the pattern and `alive` is unchanged at the end.
- Reset mid-run: `run`=1 for 5 generations, then `reset`=0 between clock edges, giving `alive`=0 and `generation`=0 with no clock. After release with `run`=0, the grid holds at 0.

Source files
------------

// File: rtl/life_array_grid.sv
// life_array_grid: ROWS x COLS B3/S23 cell array with random-access write, serial scan chain and run/step evolve.
// Build option: define LIFE_STABLE_DETECT_EN to implement the registered `stable` flag (tied to 0 otherwise).
module life_array_grid #(
    parameter  int ROWS  = 8,
    parameter  int COLS  = 8,
    parameter  int WRAP  = 0,
    parameter  int GEN_W = 16,
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int N     = ROWS * COLS
) (
    input  logic             clk,
    input  logic             reset,
    output logic [N-1:0]     alive,
    input  logic [RW-1:0]    row,
    input  logic [CW-1:0]    col,
    input  logic             val,
    input  logic             write_enb,
    input  logic             scan,
    input  logic             scan_write_val,
    input  logic             scan_write_enb,
    output logic             scan_read_val,
    input  logic             run,
    input  logic             step,
    output logic [GEN_W-1:0] generation,
    output logic             extinct,
    output logic             stable
);

    logic [N-1:0]     alive_q;
    logic [N-1:0]     alive_nxt;
    logic [N-1:0]     wr_hit;
    logic [GEN_W-1:0] gen_q;
    logic             write_ok;
    logic             evolve;

    assign write_ok = (32'(row) < ROWS) && (32'(col) < COLS);
    assign evolve   = run | step;

    // Neighbour taps are resolved at elaboration, so every cell reads fixed bits of alive_q.
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
        for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
            localparam int IDX = gc * ROWS + gr;
            logic [8:0] nb;
            logic [3:0] cnt;

            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int RR      = gr + (k / 3) - 1;
                localparam int CC      = gc + (k % 3) - 1;
                localparam int RR_WRAP = (RR + ROWS) % ROWS;
                localparam int CC_WRAP = (CC + COLS) % COLS;
                localparam bit ON_GRID = (RR >= 0) && (RR < ROWS) && (CC >= 0) && (CC < COLS);
                if (k == 4) begin : g_self
                    assign nb[k] = 1'b0;
                end else if (ON_GRID || (WRAP != 0)) begin : g_tap
                    assign nb[k] = alive_q[CC_WRAP * ROWS + RR_WRAP];
                end else begin : g_edge
                    assign nb[k] = 1'b0;
                end
            end

            assign cnt = 4'(nb[0]) + 4'(nb[1]) + 4'(nb[2]) + 4'(nb[3]) + 4'(nb[4])
                       + 4'(nb[5]) + 4'(nb[6]) + 4'(nb[7]) + 4'(nb[8]);

            assign alive_nxt[IDX] = (cnt == 4'd3) | (alive_q[IDX] & (cnt == 4'd2));
            assign wr_hit[IDX]    = write_ok && (row == RW'(gr)) && (col == CW'(gc));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alive_q <= '0;
            gen_q   <= '0;
        end else if (write_enb) begin
            if (write_ok) begin
                alive_q <= val ? (alive_q | wr_hit) : (alive_q & ~wr_hit);
                gen_q   <= '0;
            end
        end else if (scan) begin
            alive_q <= {alive_q[N-2:0], scan_write_enb ? scan_write_val : alive_q[N-1]};
            gen_q   <= '0;
        end else if (evolve) begin
            alive_q <= alive_nxt;
            gen_q   <= gen_q + GEN_W'(1);
        end
    end

`ifdef LIFE_STABLE_DETECT_EN
    logic stable_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_q <= 1'b0;
        end else if (write_enb) begin
            if (write_ok) stable_q <= 1'b0;
        end else if (scan) begin
            stable_q <= 1'b0;
        end else if (evolve) begin
            stable_q <= (alive_nxt == alive_q);
        end
    end

    assign stable = stable_q;
`else
    assign stable = 1'b0;
`endif

    assign alive         = alive_q;
    assign generation    = gen_q;
    assign extinct       = ~|alive_q;
    assign scan_read_val = alive_q[N-1];

endmodule

// File: tb/tb_life_array_grid.sv
// Bench for life_array_grid: two 5x5 instances (edges dead / toroidal) sharing one stimulus, checked against a grid model.
module tb_life_array_grid;

    localparam int R  = 5;
    localparam int C  = 5;
    localparam int N  = R * C;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    row = '0;
    logic [2:0]    col = '0;
    logic          val = 1'b0;
    logic          write_enb = 1'b0;
    logic          scan = 1'b0;
    logic          scan_write_val = 1'b0;
    logic          scan_write_enb = 1'b0;
    logic          run = 1'b0;
    logic          step = 1'b0;

    logic [N-1:0]  alive_d [2];
    logic [GW-1:0] gen_d [2];
    logic          srv_d [2];
    logic          ext_d [2];
    logic          stb_d [2];

    logic [N-1:0]  m_alive [2];
    logic [GW-1:0] m_gen;
    logic          m_stable [2];

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    life_array_grid #(.ROWS(R), .COLS(C), .WRAP(0), .GEN_W(GW)) dut_flat (
        .clk(clk), .reset(rst_n), .alive(alive_d[0]), .row(row), .col(col), .val(val),
        .write_enb(write_enb), .scan(scan), .scan_write_val(scan_write_val),
        .scan_write_enb(scan_write_enb), .scan_read_val(srv_d[0]), .run(run), .step(step),
        .generation(gen_d[0]), .extinct(ext_d[0]), .stable(stb_d[0]));

    life_array_grid #(.ROWS(R), .COLS(C), .WRAP(1), .GEN_W(GW)) dut_torus (
        .clk(clk), .reset(rst_n), .alive(alive_d[1]), .row(row), .col(col), .val(val),
        .write_enb(write_enb), .scan(scan), .scan_write_val(scan_write_val),
        .scan_write_enb(scan_write_enb), .scan_read_val(srv_d[1]), .run(run), .step(step),
        .generation(gen_d[1]), .extinct(ext_d[1]), .stable(stb_d[1]));

    function automatic logic [N-1:0] life_next(input logic [N-1:0] g, input bit wrap);
        logic [N-1:0] n;
        n = '0;
        for (int c = 0; c < C; c++) begin
            for (int r = 0; r < R; r++) begin
                int cnt;
                cnt = 0;
                for (int dc = -1; dc <= 1; dc++) begin
                    for (int dr = -1; dr <= 1; dr++) begin
                        int rr, cc;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + R) % R;
                            cc = (cc + C) % C;
                        end
                        if ((dr != 0 || dc != 0) && rr >= 0 && rr < R && cc >= 0 && cc < C)
                            cnt += int'(g[cc * R + rr]);
                    end
                end
                n[c * R + r] = (cnt == 3) || (g[c * R + r] && cnt == 2);
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_alive[k]  <= '0;
                m_stable[k] <= 1'b0;
            end
            m_gen <= '0;
        end else if (write_enb) begin
            if (row < 3'd5 && col < 3'd5) begin
                for (int k = 0; k < 2; k++) begin
                    m_alive[k][int'(col) * R + int'(row)] <= val;
                    m_stable[k] <= 1'b0;
                end
                m_gen <= '0;
            end
        end else if (scan) begin
            for (int k = 0; k < 2; k++) begin
                m_alive[k]  <= {m_alive[k][N-2:0], scan_write_enb ? scan_write_val : m_alive[k][N-1]};
                m_stable[k] <= 1'b0;
            end
            m_gen <= '0;
        end else if (run || step) begin
            for (int k = 0; k < 2; k++) begin
                logic [N-1:0] nx;
                nx = life_next(m_alive[k], k == 1);
                m_alive[k]  <= nx;
                m_stable[k] <= (nx == m_alive[k]);
            end
            m_gen <= m_gen + 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check($sformatf("alive[%0d]", k), 64'(alive_d[k]), 64'(m_alive[k]));
            check($sformatf("generation[%0d]", k), 64'(gen_d[k]), 64'(m_gen));
            check($sformatf("extinct[%0d]", k), 64'(ext_d[k]), 64'(m_alive[k] == '0));
            check($sformatf("scan_read_val[%0d]", k), 64'(srv_d[k]), 64'(m_alive[k][N-1]));
`ifdef LIFE_STABLE_DETECT_EN
            check($sformatf("stable[%0d]", k), 64'(stb_d[k]), 64'(m_stable[k]));
`else
            check($sformatf("stable[%0d]", k), 64'(stb_d[k]), 64'd0);
`endif
        end
    end

    task automatic set_idle();
        write_enb = 1'b0; scan = 1'b0; scan_write_enb = 1'b0; scan_write_val = 1'b0;
        run = 1'b0; step = 1'b0; val = 1'b0; row = '0; col = '0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        set_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_bit(input int idx, input logic v);
        @(negedge clk);
        set_idle();
        write_enb = 1'b1;
        row = 3'(idx % R);
        col = 3'(idx / R);
        val = v;
    endtask

    task automatic step_once();
        @(negedge clk);
        set_idle();
        step = 1'b1;
    endtask

    function automatic logic [N-1:0] bits3(input int a, input int b, input int c);
        logic [N-1:0] v;
        v = '0;
        v[a] = 1'b1; v[b] = 1'b1; v[c] = 1'b1;
        return v;
    endfunction

    initial begin
        logic [N-1:0] pat, rev, blk;
        int r;

        set_idle();
        repeat (2) @(negedge clk);
        check("reset alive", 64'(alive_d[0]), 64'd0);
        check("reset extinct", 64'(ext_d[0]), 64'd1);
        check("reset generation", 64'(gen_d[0]), 64'd0);
        rst_n = 1'b1;

        // Blinker
        write_bit(7, 1'b1); write_bit(12, 1'b1); write_bit(17, 1'b1);
        step_once();
        idle_cycle();
        check("blinker gen1 alive", 64'(alive_d[0]), 64'(bits3(11, 12, 13)));
        check("blinker gen1 count", 64'(gen_d[0]), 64'd1);
        step_once();
        idle_cycle();
        check("blinker gen2 alive", 64'(alive_d[0]), 64'(bits3(7, 12, 17)));
        check("blinker gen2 count", 64'(gen_d[0]), 64'd2);

        // Edge line: dies without wrap, turns into a vertical line on the torus
        do_reset();
        write_bit(0, 1'b1); write_bit(5, 1'b1); write_bit(20, 1'b1);
        step_once();
        idle_cycle();
        check("edge flat alive", 64'(alive_d[0]), 64'd0);
        check("edge flat extinct", 64'(ext_d[0]), 64'd1);
        check("edge torus alive", 64'(alive_d[1]), 64'(bits3(0, 1, 4)));

        // Block still life
        do_reset();
        blk = '0; blk[6] = 1'b1; blk[7] = 1'b1; blk[11] = 1'b1; blk[12] = 1'b1;
        write_bit(6, 1'b1); write_bit(7, 1'b1); write_bit(11, 1'b1); write_bit(12, 1'b1);
        @(negedge clk); set_idle(); run = 1'b1;
        repeat (3) @(negedge clk);
        set_idle();
        check("block alive", 64'(alive_d[0]), 64'(blk));
        check("block generation", 64'(gen_d[0]), 64'd3);
`ifdef LIFE_STABLE_DETECT_EN
        check("block stable", 64'(stb_d[0]), 64'd1);
`endif
        write_bit(24, 1'b0);
        idle_cycle();
        check("block post-write generation", 64'(gen_d[0]), 64'd0);
        check("block post-write stable", 64'(stb_d[0]), 64'd0);

        // Out-of-range write is ignored, generation kept
        step_once();
        @(negedge clk); set_idle(); write_enb = 1'b1; row = 3'd6; col = 3'd1; val = 1'b1;
        idle_cycle();
        check("oob write generation", 64'(gen_d[0]), 64'd1);
        check("oob write alive", 64'(alive_d[0]), 64'(blk));

        // Scan in a pattern, then recirculate it
        do_reset();
        pat = 25'h1A5C3E7;
        for (int i = 0; i < N; i++) rev[N-1-i] = pat[i];
        for (int i = 0; i < N; i++) begin
            @(negedge clk); set_idle();
            scan = 1'b1; scan_write_enb = 1'b1; scan_write_val = pat[i];
        end
        idle_cycle();
        check("scan load alive", 64'(alive_d[0]), 64'(rev));
        for (int i = 0; i < N; i++) begin
            @(negedge clk); set_idle();
            check("scan recirc out", 64'(srv_d[0]), 64'(pat[i]));
            scan = 1'b1;
        end
        idle_cycle();
        check("scan recirc alive", 64'(alive_d[0]), 64'(rev));

        // Write and scan together: only the write lands
        @(negedge clk); set_idle();
        write_enb = 1'b1; scan = 1'b1; scan_write_enb = 1'b1; scan_write_val = 1'b1;
        row = 3'd0; col = 3'd0; val = ~rev[0];
        idle_cycle();
        rev[0] = ~rev[0];
        check("write over scan", 64'(alive_d[0]), 64'(rev));

        // Reset in the middle of a run
        do_reset();
        write_bit(7, 1'b1); write_bit(12, 1'b1); write_bit(17, 1'b1);
        @(negedge clk); set_idle(); run = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("pre-reset generation", 64'(gen_d[0]), 64'd5);
        #1 rst_n = 1'b0;
        #1 check("async reset alive", 64'(alive_d[0]), 64'd0);
        check("async reset generation", 64'(gen_d[0]), 64'd0);
        @(negedge clk); set_idle(); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post-reset hold", 64'(alive_d[0]), 64'd0);

        // Randomized traffic, including generation wrap and out-of-range addresses
        for (int i = 0; i < 600; i++) begin
            @(negedge clk); set_idle();
            r = int'($urandom_range(0, 99));
            write_enb = (r < 25);
            scan = (r >= 20 && r < 35);
            scan_write_enb = $urandom_range(0, 1) == 1;
            scan_write_val = $urandom_range(0, 1) == 1;
            run = (r >= 35 && r < 70);
            step = (r >= 60 && r < 85);
            row = 3'($urandom_range(0, 7));
            col = 3'($urandom_range(0, 7));
            val = $urandom_range(0, 3) != 0;
            if (i % 150 == 149) begin
                repeat (20) begin
                    @(negedge clk); set_idle(); run = 1'b1;
                end
            end
        end
        idle_cycle();
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
